// File: rtl/sdram_write_burst.sv
// SDRAM write engine: ACTIVE, WRITE of a BURST_LEN-beat burst, then tWR (+ tRP when
// auto-precharging) recovery. All outputs are registered from the next-state values.
module sdram_write_burst #(
   parameter int unsigned DQ_W      = 16,
   parameter int unsigned ROW_W     = 13,
   parameter int unsigned COL_W     = 10,
   parameter int unsigned BA_W      = 2,
   parameter int unsigned BURST_LEN = 4,
   parameter int unsigned TRCD      = 2,
   parameter int unsigned TWR       = 2,
   parameter int unsigned TRP       = 3,
   parameter int unsigned AUTO_PRE  = 1
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      wr_req,
   output logic                      busy,
   output logic                      wr_done,
   input  logic [BA_W-1:0]           ba,
   input  logic [ROW_W-1:0]          row,
   input  logic [COL_W-1:0]          col,
   output logic                      wr_data_req,
   input  logic [DQ_W-1:0]           wdata,
   output logic [4+ROW_W+BA_W:0]     wr_bus,
   output logic [DQ_W-1:0]           sdram_dq_out,
   output logic                      sdram_dq_oe
);

   localparam logic [3:0] CMD_NOP = 4'b0111;
   localparam logic [3:0] CMD_ACT = 4'b0011;
   localparam logic [3:0] CMD_WR  = 4'b0100;

   localparam int unsigned MAX_A   = (TRCD > BURST_LEN) ? TRCD : BURST_LEN;
   localparam int unsigned MAX_B   = (TWR > TRP) ? TWR : TRP;
   localparam int unsigned CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
   localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

   typedef logic [CNT_W-1:0] cnt_t;

   localparam cnt_t RCD_LAST  = cnt_t'((TRCD > 1) ? TRCD - 2 : 0);
   localparam cnt_t BEAT_LAST = cnt_t'(BURST_LEN - 1);
   localparam cnt_t REC_LAST  = cnt_t'(TWR - 1);
   localparam cnt_t PRE_LAST  = cnt_t'(TRP - 1);

   typedef enum logic [2:0] {
      StIdle,
      StAct,
      StRcd,
      StWrite,
      StWrRec,
      StPreWait
   } state_e;

   state_e             state_q, state_d;
   cnt_t               cnt_q, cnt_d, cnt_inc;
   logic [BA_W-1:0]    cap_ba_q, cap_ba_d;
   logic [ROW_W-1:0]   cap_row_q, cap_row_d;
   logic [COL_W-1:0]   cap_col_q, cap_col_d;

   logic [3:0]         cmd_q, cmd_d;
   logic [ROW_W-1:0]   a_q, a_d;
   logic [BA_W-1:0]    bank_q, bank_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               req_q, req_d;
   logic               oe_q, oe_d;
   logic [DQ_W-1:0]    dq_q, dq_d;
   logic [ROW_W-1:0]   wr_addr;

   // Saturating increment: the counter never wraps back into a live range.
   assign cnt_inc = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + cnt_t'(1);

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      cap_ba_d  = cap_ba_q;
      cap_row_d = cap_row_q;
      cap_col_d = cap_col_q;
      done_d    = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (wr_req) begin
               state_d   = StAct;
               cnt_d     = '0;
               cap_ba_d  = ba;
               cap_row_d = row;
               cap_col_d = col;
            end
         end
         StAct: begin
            cnt_d   = '0;
            state_d = (TRCD > 1) ? StRcd : StWrite;
         end
         StRcd: begin
            if (cnt_q == RCD_LAST) begin
               state_d = StWrite;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         StWrite: begin
            if (cnt_q == BEAT_LAST) begin
               state_d = StWrRec;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         StWrRec: begin
            if (cnt_q == REC_LAST) begin
               cnt_d = '0;
               if (AUTO_PRE != 0) begin
                  state_d = StPreWait;
               end else begin
                  state_d = StIdle;
                  done_d  = 1'b1;
               end
            end else begin
               cnt_d = cnt_inc;
            end
         end
         StPreWait: begin
            if (cnt_q == PRE_LAST) begin
               state_d = StIdle;
               cnt_d   = '0;
               done_d  = 1'b1;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         default: begin
            state_d = StIdle;
            cnt_d   = '0;
         end
      endcase
   end

   always_comb begin
      wr_addr              = '0;
      wr_addr[COL_W-1:0]   = cap_col_q;
      wr_addr[10]          = (AUTO_PRE != 0);
   end

   // Outputs are decoded from the next state so the registered bus lines up with it.
   always_comb begin
      cmd_d  = CMD_NOP;
      a_d    = '0;
      bank_d = '0;
      busy_d = (state_d != StIdle);
      if (state_d != StIdle) begin
         bank_d = cap_ba_d;
      end
      unique case (state_d)
         StAct: begin
            cmd_d = CMD_ACT;
            a_d   = cap_row_d;
         end
         StWrite: begin
            if (cnt_d == '0) begin
               cmd_d = CMD_WR;
               a_d   = wr_addr;
            end
         end
         default: begin
         end
      endcase
      // Request runs one cycle ahead of each beat on the pad.
      req_d = ((state_d == StWrite) && (cnt_d < BEAT_LAST))
           || ((TRCD == 1) && (state_d == StAct))
           || ((state_d == StRcd) && (cnt_d == RCD_LAST));
      oe_d  = req_q;
      dq_d  = req_q ? wdata : '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         cap_ba_q  <= '0;
         cap_row_q <= '0;
         cap_col_q <= '0;
         cmd_q     <= CMD_NOP;
         a_q       <= '0;
         bank_q    <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         req_q     <= 1'b0;
         oe_q      <= 1'b0;
         dq_q      <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         cap_ba_q  <= cap_ba_d;
         cap_row_q <= cap_row_d;
         cap_col_q <= cap_col_d;
         cmd_q     <= cmd_d;
         a_q       <= a_d;
         bank_q    <= bank_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         req_q     <= req_d;
         oe_q      <= oe_d;
         dq_q      <= dq_d;
      end
   end

   assign wr_bus       = {cmd_q, 1'b1, a_q, bank_q};
   assign busy         = busy_q;
   assign wr_done      = done_q;
   assign wr_data_req  = req_q;
   assign sdram_dq_oe  = oe_q;
   assign sdram_dq_out = dq_q;

endmodule
